// File: rtl/nor_gate_unit.sv
// Bitwise NOR cell with three views of one function: combinational X,
// registered Y, and a registered "all inputs low" flag Z.
module nor_gate_unit #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] X,
    output logic [WIDTH-1:0] Y,
    output logic             Z
);

    logic [WIDTH-1:0] nor_bits;
    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] y_q;
    logic             z_d;
    logic             z_q;

    always_comb begin
        nor_bits = ~(A | B);
        y_d      = nor_bits;
        z_d      = ~((|A) | (|B));
    end

    // X is taken straight from the operands so it never waits on a clock edge.
    assign X = nor_bits;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q <= '0;
            z_q <= 1'b0;
        end else begin
            y_q <= y_d;
            z_q <= z_d;
        end
    end

    assign Y = y_q;
    assign Z = z_q;

endmodule

// File: tb/tb_nor_gate_unit.sv
// Bench for nor_gate_unit: a WIDTH=1 and a WIDTH=4 instance checked against a
// per-bit behavioural model plus directed literal expectations.
module tb_nor_gate_unit;

    logic       clk;
    logic       rst;
    logic [0:0] a1, b1, x1, y1;
    logic       z1;
    logic [3:0] a4, b4, x4, y4;
    logic       z4;

    int  vectors;
    int  miscompares;
    bit  chk_en;

    logic [0:0] exp_y1;
    logic       exp_z1;
    logic [3:0] exp_y4;
    logic       exp_z4;

    nor_gate_unit #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .X(x1), .Y(y1), .Z(z1)
    );

    nor_gate_unit #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .A(a4), .B(b4), .X(x4), .Y(y4), .Z(z4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A result bit is 1 only when both operand bits are 0.
    function automatic logic [63:0] nor_ref(input logic [63:0] a, input logic [63:0] b, input int w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < w; i++)
            r[i] = (a[i] === 1'b0 && b[i] === 1'b0) ? 1'b1 : 1'b0;
        return r;
    endfunction

    function automatic logic all_low(input logic [63:0] a, input logic [63:0] b, input int w);
        int ones;
        ones = 0;
        for (int i = 0; i < w; i++) begin
            if (a[i] !== 1'b0) ones++;
            if (b[i] !== 1'b0) ones++;
        end
        return (ones == 0);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Previous-edge model: what Y and Z must hold after each edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_y1 = '0; exp_z1 = 1'b0;
            exp_y4 = '0; exp_z4 = 1'b0;
        end else begin
            exp_y1 = 1'(nor_ref(64'(a1), 64'(b1), 1));
            exp_z1 = all_low(64'(a1), 64'(b1), 1);
            exp_y4 = 4'(nor_ref(64'(a4), 64'(b4), 4));
            exp_z4 = all_low(64'(a4), 64'(b4), 4);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("x1_model", 64'(x1), nor_ref(64'(a1), 64'(b1), 1));
            check("y1_model", 64'(y1), 64'(exp_y1));
            check("z1_model", 64'(z1), 64'(exp_z1));
            check("x4_model", 64'(x4), nor_ref(64'(a4), 64'(b4), 4));
            check("y4_model", 64'(y4), 64'(exp_y4));
            check("z4_model", 64'(z4), 64'(exp_z4));
        end
    end

    initial begin
        logic [3:0] tt_x;
        vectors = 0;
        miscompares = 0;
        chk_en = 1'b0;
        rst = 1'b1;
        a1 = '0; b1 = '0; a4 = '0; b4 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_y1", 64'(y1), 64'd0);
        check("reset_z1", 64'(z1), 64'd0);
        check("reset_y4", 64'(y4), 64'd0);
        check("reset_z4", 64'(z4), 64'd0);
        check("reset_x1_live", 64'(x1), 64'd1);

        // Exhaustive truth table, no clock edge involved (rst held).
        tt_x = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            a1 = 1'(i >> 1);
            b1 = 1'(i);
            #1;
            check($sformatf("truth_%0d%0d", a1, b1), 64'(x1), 64'(tt_x[i]));
        end

        // Release reset; first edge captures A=B=0.
        @(negedge clk);
        a1 = '0; b1 = '0; a4 = '0; b4 = '0;
        rst = 1'b0;
        chk_en = 1'b1;
        @(posedge clk); #1;
        check("edge1_y1", 64'(y1), 64'd1);
        check("edge1_z1", 64'(z1), 64'd1);
        a1 = 1'b1;
        #1;
        check("x1_immediate", 64'(x1), 64'd0);
        check("y1_holds", 64'(y1), 64'd1);
        @(posedge clk); #1;
        check("edge2_y1", 64'(y1), 64'd0);
        check("edge2_z1", 64'(z1), 64'd0);

        // Asynchronous reset between edges.
        a1 = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_y1", 64'(y1), 64'd1);
        check("pre_rst_z1", 64'(z1), 64'd1);
        #3;
        rst = 1'b1;
        #1;
        check("async_y1", 64'(y1), 64'd0);
        check("async_z1", 64'(z1), 64'd0);
        check("async_x1", 64'(x1), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("hold_y1", 64'(y1), 64'd0);
            check("hold_z1", 64'(z1), 64'd0);
            check("hold_x1", 64'(x1), 64'd1);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("release_y1", 64'(y1), 64'd1);
        check("release_z1", 64'(z1), 64'd1);

        // WIDTH=4 directed.
        a4 = 4'b0101; b4 = 4'b0010;
        #1;
        check("w4_x", 64'(x4), 64'h8);
        @(posedge clk); #1;
        check("w4_y", 64'(y4), 64'h8);
        check("w4_z", 64'(z4), 64'd0);
        a4 = 4'b0000; b4 = 4'b0000;
        #1;
        check("w4_x_zero", 64'(x4), 64'hf);
        @(posedge clk); #1;
        check("w4_y_zero", 64'(y4), 64'hf);
        check("w4_z_zero", 64'(z4), 64'd1);

        // Random soak: new operands every cycle, model checks each negedge.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 3) == 0) begin
                a1 = '0; b1 = '0; a4 = '0; b4 = '0;
            end else begin
                a1 = 1'($urandom); b1 = 1'($urandom);
                a4 = 4'($urandom); b4 = 4'($urandom);
            end
            #1;
            check("soak_x1", 64'(x1), nor_ref(64'(a1), 64'(b1), 1));
            check("soak_x4", 64'(x4), nor_ref(64'(a4), 64'(b4), 4));
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
